// File: rtl/dac_tx.sv
// Left-justified two-slot serial audio transmitter fed from a small sample FIFO.
// Slot words are popped on the sclk falling edge that starts each slot.
module dac_tx #(
    parameter int DWIDTH = 32,
    parameter int SWIDTH = 20,
    parameter int CLKDIV = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              clr_flags,
    output logic              sclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              full,
    output logic              empty,
    output logic              underrun,
    output logic              overflow
);
    localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BITW = $clog2(SWIDTH);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} slot_e;

    slot_e             state_q, state_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic              sclk_q, sclk_d;
    logic [BITW-1:0]   bit_q, bit_d;
    logic [SWIDTH-1:0] sh_q, sh_d;
    logic [SWIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CNTW-1:0]   occ_q, occ_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              urun_evt_q, urun_evt_d;
    logic              underrun_q, underrun_d, overflow_q, overflow_d;
    logic              div_last, fall, slot_start, pop, push, drop;

    assign div_last   = (div_q == DIVW'(CLKDIV - 1));
    assign fall       = div_last & sclk_q;
    assign slot_start = fall & (bit_q == BITW'(SWIDTH - 1));
    assign pop        = slot_start & ~empty_q;
    // A same-cycle pop frees a slot, so a write to a full FIFO still lands.
    assign push       = wr_en & (~full_q | pop);
    assign drop       = wr_en & full_q & ~pop;

    always_comb begin
        div_d   = div_last ? '0 : div_q + DIVW'(1);
        sclk_d  = sclk_q ^ div_last;
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        if (slot_start) begin
            state_d = (state_q == LEFT) ? RIGHT : LEFT;
            bit_d   = '0;
            sh_d    = pop ? mem_q[rp_q] : '0;
        end else if (fall) begin
            bit_d = bit_q + BITW'(1);
            sh_d  = {sh_q[SWIDTH-2:0], 1'b0};
        end
        wp_d    = push ? wp_q + PTRW'(1) : wp_q;
        rp_d    = pop ? rp_q + PTRW'(1) : rp_q;
        occ_d   = occ_q + CNTW'(push) - CNTW'(pop);
        full_d  = (occ_d == CNTW'(DEPTH));
        empty_d = (occ_d == '0);
        // Underrun is reported one cycle after the slot-start edge it belongs to.
        urun_evt_d = slot_start & empty_q;
        underrun_d = urun_evt_q | (underrun_q & ~clr_flags);
        overflow_d = drop | (overflow_q & ~clr_flags);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RIGHT;
            div_q      <= '0;
            sclk_q     <= 1'b0;
            bit_q      <= BITW'(SWIDTH - 1);
            sh_q       <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            occ_q      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            urun_evt_q <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            occ_q      <= occ_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            urun_evt_q <= urun_evt_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wp_q] <= wdata[SWIDTH-1:0];
    end

    generate
        if (DWIDTH > SWIDTH) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^wdata[DWIDTH-1:SWIDTH];
        end
    endgenerate

    assign sclk     = sclk_q;
    assign lrclk    = (state_q == RIGHT);
    assign sdata    = sh_q[SWIDTH-1];
    assign full     = full_q;
    assign empty    = empty_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;
endmodule
